led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 45 ++++
 rtl/led_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED pattern sequencer.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT = 2'd0,
      MODE_SHIFT = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_OFF   = 2'd3
   } mode_t;

   localparam int WAIT_TIME_DEFAULT       = 13500000;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 270000;

   localparam int TICK_W = 24;
   localparam int DEB_W  = 20;
   localparam int LED_W  = 6;

   function automatic mode_t next_mode(input mode_t m);
      mode_t n;
      case (m)
         MODE_COUNT: n = MODE_SHIFT;
         MODE_SHIFT: n = MODE_BLINK;
         MODE_BLINK: n = MODE_OFF;
         default:    n = MODE_COUNT;
      endcase
      return n;
   endfunction

   // Only SHIFT starts from a lit LED; every other mode starts dark.
   function automatic logic [LED_W-1:0] mode_seed(input mode_t m);
      return (m == MODE_SHIFT) ? 6'h01 : 6'h00;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, level debouncer and single-cycle press pulse for
// one raw push-button input.
module btn_debounce
   import led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);

   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   logic             sync0;
   logic             sync1;
   logic             level;
   logic [DEB_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync0 <= raw;
         sync1 <= sync0;
         press <= 1'b0;
         // Any cycle that agrees with the accepted level restarts the count.
         if (sync1 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync1;
            press <= sync1;
         end else begin
            cnt <= cnt + DEB_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: tick counter plus a mode/pattern state machine
// driven by two debounced buttons (mode select, pause).
module led_sequencer
   import led_pkg::*;
#(
   parameter int WAIT_TIME       = WAIT_TIME_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_mode,
   input  logic             btn_pause,
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic             paused
);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WAIT_TIME - 1);

   logic              mode_press;
   logic              pause_press;
   logic              tick;

   mode_t             mode_q;
   mode_t             mode_d;
   logic [LED_W-1:0]  led_d;
   logic              paused_d;
   logic              dir_up;
   logic              dir_up_d;
   logic [TICK_W-1:0] tcnt;
   logic [TICK_W-1:0] tcnt_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_mode),
      .press (mode_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_pause),
      .press (pause_press)
   );

   assign tick = (tcnt == TICK_LAST);
   assign mode = mode_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_COUNT;
         led    <= '0;
         paused <= 1'b0;
         dir_up <= 1'b1;
         tcnt   <= '0;
      end else begin
         mode_q <= mode_d;
         led    <= led_d;
         paused <= paused_d;
         dir_up <= dir_up_d;
         tcnt   <= tcnt_d;
      end
   end

   always_comb begin
      mode_d   = mode_q;
      led_d    = led;
      paused_d = paused;
      dir_up_d = dir_up;
      tcnt_d   = tick ? '0 : tcnt + TICK_W'(1);

      // Pause is independent of the mode button; both may land together.
      if (pause_press)
         paused_d = ~paused;

      if (mode_press) begin
         // A mode change restarts the tick period and swallows any tick.
         mode_d   = next_mode(mode_q);
         tcnt_d   = '0;
         led_d    = mode_seed(next_mode(mode_q));
         dir_up_d = 1'b1;
      end else if (tick && !paused) begin
         unique case (mode_q)
            MODE_COUNT: led_d = led + 6'd1;
            MODE_SHIFT: begin
               // Bounce at the ends so neither end position repeats.
               if (dir_up) begin
                  if (led[LED_W-1]) begin
                     led_d    = led >> 1;
                     dir_up_d = 1'b0;
                  end else begin
                     led_d = led << 1;
                  end
               end else begin
                  if (led[0]) begin
                     led_d    = led << 1;
                     dir_up_d = 1'b1;
                  end else begin
                     led_d = led >> 1;
                  end
               end
            end
            MODE_BLINK: led_d = ~led;
            default:    led_d = '0;
         endcase
      end
   end

endmodule
